// File: rtl/matrix_addsub_seq_if.sv
`default_nettype none
// ============================================================================
// matrix_addsub_seq_if : request/operand/result bundle for matrix_addsub_seq
// Revision: 1.0
// ============================================================================
interface matrix_addsub_seq_if #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5
);
    logic                              start;
    logic [1:0]                        mode;
    logic [1:0]                        matrix_size;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_a;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_b;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0] result_out;
    logic                              overflow;
    logic                              busy;
    logic                              done;

    modport master (
        output start, mode, matrix_size, matrix_a, matrix_b,
        input  result_out, overflow, busy, done
    );

    modport slave (
        input  start, mode, matrix_size, matrix_a, matrix_b,
        output result_out, overflow, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/matrix_addsub_seq.sv
`default_nettype none
// ============================================================================
// matrix_addsub_seq : sequential LANES-wide element-wise matrix add/sub
// Revision: 1.0
// ============================================================================
module matrix_addsub_seq #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int LANES   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_addsub_seq_if.slave  bus
);
    localparam int NUM   = MAX_DIM * MAX_DIM;
    localparam int VW    = NUM * DATA_W;
    localparam int IDX_W = $clog2(NUM + LANES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] n_q,     n_d;
    logic [VW-1:0]    a_q,     a_d;
    logic [VW-1:0]    b_q,     b_d;
    logic [1:0]       mode_q,  mode_d;
    logic [VW-1:0]    res_q,   res_d;
    logic             ovf_q,   ovf_d;

    logic [DATA_W-1:0] elem_val [NUM];
    logic [NUM-1:0]    elem_ovf;
    logic [3:0]        dim;
    logic [7:0]        n_full;

    // Sign-extend to DATA_W+1 bits; overflow shows up as disagreeing top two bits.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_elem
        logic [DATA_W:0] ext_a;
        logic [DATA_W:0] ext_b;
        logic [DATA_W:0] sum;
        assign ext_a = {a_q[gi*DATA_W + DATA_W-1], a_q[gi*DATA_W +: DATA_W]};
        assign ext_b = {b_q[gi*DATA_W + DATA_W-1], b_q[gi*DATA_W +: DATA_W]};
        assign sum   = mode_q[0] ? (ext_a - ext_b) : (ext_a + ext_b);
        assign elem_ovf[gi] = sum[DATA_W] ^ sum[DATA_W-1];
        assign elem_val[gi] = (elem_ovf[gi] && mode_q[1])
                            ? (sum[DATA_W] ? SAT_MIN : SAT_MAX)
                            : sum[DATA_W-1:0];
    end

    always_comb begin
        dim = {2'b00, bus.matrix_size} + 4'd2;
        if (dim > 4'(MAX_DIM)) begin
            dim = 4'(MAX_DIM);
        end
        n_full = {4'b0000, dim} * {4'b0000, dim};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.matrix_a;
                    b_d     = bus.matrix_b;
                    mode_d  = bus.mode;
                    n_d     = IDX_W'(n_full);
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Only the current lane window of active elements is committed.
                for (int i = 0; i < NUM; i++) begin
                    if ((IDX_W'(i) >= idx_q) &&
                        (IDX_W'(i) < idx_q + IDX_W'(LANES)) &&
                        (IDX_W'(i) < n_q)) begin
                        res_d[i*DATA_W +: DATA_W] = elem_val[i];
                        ovf_d = ovf_d | elem_ovf[i];
                    end
                end
                idx_d = idx_q + IDX_W'(LANES);
                if (idx_q + IDX_W'(LANES) >= n_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.result_out = res_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_matrix_addsub_seq.sv
`default_nettype none
// ============================================================================
// tb_matrix_addsub_seq : directed + random checks against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_matrix_addsub_seq;
    localparam int DW   = 8;
    localparam int MD   = 5;
    localparam int LN   = 5;
    localparam int NUM  = MD * MD;
    localparam int VW   = NUM * DW;
    localparam int MAXV = (1 << (DW-1)) - 1;
    localparam int MINV = -(1 << (DW-1));

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    matrix_addsub_seq_if #(.DATA_W(DW), .MAX_DIM(MD)) bus ();

    matrix_addsub_seq #(.DATA_W(DW), .MAX_DIM(MD), .LANES(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < NUM; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Reference: plain integer arithmetic per element, then wrap or clamp.
    task automatic model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [1:0] m, input logic [1:0] sz,
                         output logic [VW-1:0] r, output logic o, output int n);
        int dim, va, vb, s;
        dim = int'(sz) + 2;
        if (dim > MD) dim = MD;
        n = dim * dim;
        r = '0;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            va = int'($signed(a[i*DW +: DW]));
            vb = int'($signed(b[i*DW +: DW]));
            s  = m[0] ? va - vb : va + vb;
            if (s > MAXV || s < MINV) begin
                o = 1'b1;
                if (m[1]) s = (s > MAXV) ? MAXV : MINV;
            end
            r[i*DW +: DW] = DW'(s);
        end
    endtask

    task automatic run_op(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [1:0] m, input logic [1:0] sz, input bit disturb);
        logic [VW-1:0] er;
        logic          eo;
        int            n, runs, lat, bcnt, extra;
        model(a, b, m, sz, er, eo, n);
        runs = (n + LN - 1) / LN;
        @(negedge clk);
        bus.matrix_a = a; bus.matrix_b = b; bus.mode = m; bus.matrix_size = sz; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 1;
        bcnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 64) begin
            if (disturb && lat <= 2) begin
                bus.start    = 1'b1;
                bus.matrix_a = rand_vec();
                bus.matrix_b = rand_vec();
                bus.mode     = ~m;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) bcnt++;
        end
        chk({tag, ".latency"}, VW'(lat), VW'(runs + 1));
        chk({tag, ".busy_cycles"}, VW'(bcnt), VW'(runs));
        chk({tag, ".result"}, bus.result_out, er);
        chk({tag, ".overflow"}, VW'(bus.overflow), VW'(eo));
        if (disturb) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".done_pulse"}, VW'({bus.busy, bus.done}), VW'(0));
        bus.matrix_a = rand_vec();
        bus.matrix_b = rand_vec();
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
        end
        chk({tag, ".no_extra"}, VW'(extra), VW'(0));
        chk({tag, ".hold"}, {bus.result_out[VW-2:0], bus.overflow}, {er[VW-2:0], eo});
    endtask

    initial begin
        logic [VW-1:0] a, b, exp_vec;
        int            seen;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 2'b00; bus.matrix_size = 2'b00;
        bus.matrix_a = '0; bus.matrix_b = '0;
        #12;
        chk("reset.result", bus.result_out, '0);
        chk("reset.flags", VW'({bus.overflow, bus.busy, bus.done}), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 2x2 wrap add overflow, then saturating add
        a = '0; b = '0; a[7:0] = 8'h7F; b[7:0] = 8'h01;
        run_op("add_wrap", a, b, 2'b00, 2'b00, 1'b0);
        chk("add_wrap.elem0", VW'(bus.result_out[7:0]), VW'(8'h80));
        chk("add_wrap.upper", VW'(bus.result_out[VW-1:32]), VW'(0));
        run_op("add_sat", a, b, 2'b10, 2'b00, 1'b0);
        chk("add_sat.elem0", VW'(bus.result_out[7:0]), VW'(8'h7F));

        a = '0; b = '0; a[7:0] = 8'h80; b[7:0] = 8'h01;
        run_op("sub_sat", a, b, 2'b11, 2'b00, 1'b0);
        chk("sub_sat.elem0", VW'({bus.result_out[7:0], bus.overflow}), VW'({8'h80, 1'b1}));
        run_op("sub_wrap", a, b, 2'b01, 2'b00, 1'b0);
        chk("sub_wrap.elem0", VW'({bus.result_out[7:0], bus.overflow}), VW'({8'h7F, 1'b1}));

        for (int i = 0; i < NUM; i++) begin
            a[i*DW +: DW] = DW'(i + 10);
            b[i*DW +: DW] = DW'(i);
            exp_vec[i*DW +: DW] = 8'h0A;
        end
        run_op("full_sub", a, b, 2'b01, 2'b11, 1'b0);
        chk("full_sub.all0A", {bus.result_out[VW-2:0], bus.overflow}, {exp_vec[VW-2:0], 1'b0});

        run_op("disturb", rand_vec(), rand_vec(), 2'b00, 2'b11, 1'b1);
        run_op("after_disturb", rand_vec(), rand_vec(), 2'b10, 2'b01, 1'b0);

        // Abort a 5x5 op in its second RUN cycle
        @(negedge clk);
        bus.matrix_a = rand_vec(); bus.matrix_b = rand_vec();
        bus.mode = 2'b00; bus.matrix_size = 2'b11; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.result", bus.result_out, '0);
        chk("abort.flags", VW'({bus.overflow, bus.busy, bus.done}), VW'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen++;
        end
        chk("abort.no_done", VW'(seen), VW'(0));
        run_op("after_rst", rand_vec(), rand_vec(), 2'b00, 2'b01, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_op($sformatf("rand%0d", k), rand_vec(), rand_vec(),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_addsub_seq.md
MATRIX_ADDSUB_SEQ -- requirements
Module: matrix_addsub_seq

Interface
REQ-001 SHALL have parameter DATA_W, 8, signed element width in bits (two's complement).
REQ-002 SHALL have parameter MAX_DIM, 5, largest supported square matrix dimension.
REQ-003 SHALL have parameter LANES, 5, elements processed per clock (1..MAX_DIM*MAX_DIM).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port mode  input  2  00 add-wrap, 01 sub-wrap, 10 add-saturate, 11 sub-saturate.
REQ-008 SHALL have port matrix_size  input  2  dimension = matrix_size+2, clamped to MAX_DIM.
REQ-009 SHALL have port matrix_a  input  MAX_DIM*MAX_DIM*DATA_W  row-major operand A; element i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port matrix_b  input  MAX_DIM*MAX_DIM*DATA_W  operand B, same packing.
REQ-011 SHALL have port result_out  output  MAX_DIM*MAX_DIM*DATA_W  registered result, same packing.
REQ-012 SHALL have port overflow  output  1  registered; high if any active element overflowed.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE, start=1: SHALL latch matrix_a, matrix_b, mode, matrix_size; clear result_out and overflow; set element index to 0; go to RUN.
REQ-017 IDLE, start=0: SHALL stay in IDLE and hold all outputs.
REQ-018 Active element count N SHALL be dim*dim (4, 9, 16, 25 for MAX_DIM=5); elements with index >= N SHALL read 0 in result_out.
REQ-019 Each RUN cycle SHALL compute elements idx..idx+LANES-1 that are < N, write them to result_out, and advance idx by LANES.
REQ-020 RUN SHALL last exactly ceil(N/LANES) cycles; it goes to DONE after the cycle in which idx+LANES >= N.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 Result latency SHALL be 1+ceil(N/LANES) cycles from the start-sampling edge to the done-high cycle.
REQ-023 Arithmetic SHALL use the latched operands only; input changes after the accepted start have no effect.
REQ-024 Each element SHALL be computed at DATA_W+1 bits signed: a+b for add modes, a-b for sub modes.
REQ-025 Element overflow SHALL be true when the DATA_W+1-bit result is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 Wrap modes SHALL store the low DATA_W bits of the result.
REQ-027 Saturate modes SHALL clamp to 2^(DATA_W-1)-1 on positive overflow and -2^(DATA_W-1) on negative overflow.
REQ-028 overflow SHALL be sticky within an operation (OR of all active elements) in every mode, including saturate modes.
REQ-029 start in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-030 result_out and overflow SHALL be stable from the done cycle until the next accepted start.
REQ-031 A matrix_size that encodes dim > MAX_DIM SHALL be treated as MAX_DIM.

Reset
REQ-032 With rst_n=0, the block SHALL enter IDLE immediately, independent of clk.
REQ-033 During reset, result_out, overflow, busy and done SHALL all be 0, and the internal index SHALL be 0.
REQ-034 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-035 Bench SHALL cover: defaults, size=00, mode=00, A[0]=0x7F, B[0]=0x01, all other elements 0 -> busy for 1 cycle, then done; result[0]=0x80, overflow=1, elements 4..24 = 0.
REQ-036 Bench SHALL cover: same stimulus with mode=10 -> result[0]=0x7F, overflow=1.
REQ-037 Bench SHALL cover: mode=11, A[0]=0x80, B[0]=0x01 -> result[0]=0x80 (-128), overflow=1; mode=01 on the same operands -> 0x7F, overflow=1.
REQ-038 Bench SHALL cover: size=11, mode=01, A[i]=i+10, B[i]=i -> busy 5 cycles, done exactly 6 cycles after start; all 25 results = 0x0A, overflow=0.
REQ-039 Bench SHALL cover: start re-pulsed and operands changed during RUN -> no effect on the result and a single done; a later start in IDLE is accepted.
REQ-040 Bench SHALL cover: rst_n=0 in the 2nd RUN cycle of a 5x5 operation -> outputs 0 immediately and no done; a new 3x3 add then completes in 3 cycles with correct values.
